if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline. Holds the PC and drives the instruction-ROM address.
- Registers the fetched word into the IF/ID pipeline register that feeds the ID-stage controller.
- Closes the loop on the controller's npc_op: when that decision reaches EX with its resolved operands, this block computes the next PC, redirects fetch and squashes the wrong-path instruction.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded by reset.
- NOP_INST, 32'h0000_0013, word injected on flush (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- irom_addr  out  32  byte address of the current fetch; equals the PC register; combinational ROM read.
- irom_inst  in  32  instruction word at irom_addr, same cycle.
- stall  in  1  from hazard unit: hold PC and IF/ID.
- ex_valid  in  1  EX-stage instruction is real (not a bubble).
- ex_npc_op  in  2  npc_op carried to EX (PC4/JMP/JAL/JALR).
- ex_br_taken  in  1  branch comparator result for the EX instruction.
- ex_pc  in  32  PC of the EX instruction.
- ex_imm  in  32  sign-extended immediate of the EX instruction.
- ex_rs1  in  32  forwarded rs1 value, used by JALR.
- id_inst  out  32  IF/ID instruction register.
- id_pc  out  32  IF/ID PC.
- id_pc4  out  32  IF/ID PC+4, consumed by RF_WSEL_PC4.
- id_valid  out  1  IF/ID holds a real instruction.
- redirect  out  1  combinational: the EX instruction redirects fetch this cycle. Also drives the ID/EX flush.
- target_misaligned  out  1  registered one-cycle pulse: the last redirect target had bit1 set.

Behaviour:
- Reset (rst_n=0 at an edge):
  - pc=RESET_PC, id_inst=NOP_INST, id_pc=0, id_pc4=0, id_valid=0, target_misaligned=0.
  - Reset wins over stall and redirect. A reset mid-redirect discards the target.
- NPC codes: PC4=2'b00, JMP=2'b01, JAL=2'b10, JALR=2'b11.
- Redirect condition: redirect = ex_valid & (op==JAL | op==JALR | (op==JMP & ex_br_taken)).
- Redirect target:
  - JMP and JAL: ex_pc+ex_imm.
  - JALR: (ex_rs1+ex_imm) with bit0 cleared.
  - All arithmetic is 32-bit modulo 2^32, carry discarded.
- Target bit1 set: the target is still used with bits[1:0] forced to 0, and target_misaligned=1 on the next cycle for exactly one cycle.
- Sequential PC = pc+4; 32'hFFFF_FFFC wraps to 0.
- Per edge, priority is reset > redirect > stall > normal.
  - Redirect: pc<=target; id_inst<=NOP_INST; id_valid<=0; id_pc and id_pc4 hold. This applies even if stall=1, because the stalled ID instruction is wrong-path.
  - Stall, no redirect: pc, id_inst, id_pc, id_pc4 and id_valid all hold. irom_addr stays constant.
  - Normal: pc<=pc+4; id_inst<=irom_inst; id_pc<=pc; id_pc4<=pc+4; id_valid<=1.
- Latency:
  - One cycle from irom_addr to id_inst.
  - Redirect penalty is 2 bubbles: the IF/ID squash here plus the ID/EX squash done by the pipeline on redirect.
- ex_valid=0 never redirects, whatever ex_npc_op and ex_br_taken are.
- First fetch: in the cycle rst_n is sampled high, irom_addr=RESET_PC. After the next edge, id_valid=1 and id_inst=ROM[RESET_PC].
- No internal state machine beyond pc, the IF/ID register and the misalign flop.

Decomposition:
- Shared package / defines.vh: NPC_PC4, NPC_JMP, NPC_JAL, NPC_JALR codes, the NOP_INST constant and RESET_PC default. The controller and this block use the same encodings.
- One combinational sub-module, npc_calc: inputs ex_npc_op, ex_br_taken, ex_valid, ex_pc, ex_imm, ex_rs1, pc; outputs redirect, next_pc, misaligned.
- if_stage holds only the registers and the priority logic.

Test Plan:
- Reset release with RESET_PC=0, ROM[0]=32'h00500093, stall=0, ex_valid=0 -> irom_addr=0, 4, 8 on successive cycles; after the first edge id_inst=32'h00500093, id_pc=0, id_pc4=4, id_valid=1.
- Taken branch: ex_valid=1, op=JMP, ex_br_taken=1, ex_pc=0x10, ex_imm=-8 -> redirect=1; next cycle pc=0x08, id_inst=NOP_INST, id_valid=0. With ex_br_taken=0 there is no redirect.
- JALR: ex_rs1=0x101, ex_imm=4 -> pc=0x104. With ex_rs1=0x102, ex_imm=0 -> pc=0x100 and target_misaligned=1 for exactly one cycle.
- Stall 3 cycles at pc=0x20 -> irom_addr stays 0x20 and the IF/ID outputs are unchanged. Stall plus JAL redirect (ex_pc=0x1C, ex_imm=0x40) in the same cycle -> pc=0x5C and id_valid=0.
- Wrap: pc=0xFFFFFFFC, normal fetch -> next pc=0, id_pc4=0. With ex_valid=0 and op=JAL -> no redirect.
- Assert rst_n=0 in the same cycle as a JAL redirect -> pc=RESET_PC, id_valid=0, target_misaligned=0.

Source files
------------

// File: rtl/if_stage_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | if_stage_pkg : next-PC encodings and fetch constants shared with   |
// | the ID-stage controller.                Rev 1.0                    |
// +--------------------------------------------------------------------+
package if_stage_pkg;

  typedef enum logic [1:0] {
    NPC_PC4  = 2'b00,
    NPC_JMP  = 2'b01,
    NPC_JAL  = 2'b10,
    NPC_JALR = 2'b11
  } npc_op_e;

  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage : if_stage_pkg
`default_nettype wire

// File: rtl/if_stage_npc_calc.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | npc_calc : resolves the EX-stage npc_op into a redirect decision   |
// | and the next fetch address.             Rev 1.0                    |
// +--------------------------------------------------------------------+
module npc_calc
  import if_stage_pkg::*;
(
  input  logic [1:0]  ex_npc_op,
  input  logic        ex_br_taken,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_rs1,
  input  logic [31:0] pc,
  output logic        redirect,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  logic        is_jal;
  logic        is_jalr;
  logic        is_taken_br;
  logic [31:0] raw_target;
  logic [31:0] target;

  assign is_jal      = (ex_npc_op == NPC_JAL);
  assign is_jalr     = (ex_npc_op == NPC_JALR);
  assign is_taken_br = (ex_npc_op == NPC_JMP) && ex_br_taken;

  assign redirect = ex_valid && (is_jal || is_jalr || is_taken_br);

  always_comb begin
    raw_target = ex_pc + ex_imm;
    if (is_jalr) begin
      raw_target = (ex_rs1 + ex_imm) & 32'hFFFF_FFFE;
    end
    // A halfword-aligned target is still taken, but snapped to a word.
    target = raw_target;
    if (raw_target[1]) begin
      target[1:0] = 2'b00;
    end
  end

  assign misaligned = redirect && raw_target[1];
  assign next_pc    = redirect ? target : (pc + 32'd4);

endmodule : npc_calc
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | if_stage : PC register, IF/ID pipeline register and redirect       |
// | priority for the RV32I fetch stage.     Rev 1.0                    |
// +--------------------------------------------------------------------+
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] irom_addr,
  input  logic [31:0] irom_inst,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic [1:0]  ex_npc_op,
  input  logic        ex_br_taken,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_rs1,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic        id_valid,
  output logic        redirect,
  output logic        target_misaligned
);

  logic [31:0] pc_q,       pc_d;
  logic [31:0] id_inst_q,  id_inst_d;
  logic [31:0] id_pc_q,    id_pc_d;
  logic [31:0] id_pc4_q,   id_pc4_d;
  logic        id_valid_q, id_valid_d;
  logic        misalign_q, misalign_d;

  logic [31:0] npc;
  logic        npc_misaligned;
  logic [31:0] pc_plus4;

  npc_calc u_npc_calc (
    .ex_npc_op   (ex_npc_op),
    .ex_br_taken (ex_br_taken),
    .ex_valid    (ex_valid),
    .ex_pc       (ex_pc),
    .ex_imm      (ex_imm),
    .ex_rs1      (ex_rs1),
    .pc          (pc_q),
    .redirect    (redirect),
    .next_pc     (npc),
    .misaligned  (npc_misaligned)
  );

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d       = pc_q;
    id_inst_d  = id_inst_q;
    id_pc_d    = id_pc_q;
    id_pc4_d   = id_pc4_q;
    id_valid_d = id_valid_q;
    misalign_d = npc_misaligned;
    // Redirect overrides stall: whatever ID is holding is wrong-path.
    if (redirect) begin
      pc_d       = npc;
      id_inst_d  = NOP_INST;
      id_valid_d = 1'b0;
    end else if (!stall) begin
      pc_d       = pc_plus4;
      id_inst_d  = irom_inst;
      id_pc_d    = pc_q;
      id_pc4_d   = pc_plus4;
      id_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      id_inst_q  <= NOP_INST;
      id_pc_q    <= 32'd0;
      id_pc4_q   <= 32'd0;
      id_valid_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_inst_q  <= id_inst_d;
      id_pc_q    <= id_pc_d;
      id_pc4_q   <= id_pc4_d;
      id_valid_q <= id_valid_d;
      misalign_q <= misalign_d;
    end
  end

  assign irom_addr         = pc_q;
  assign id_inst           = id_inst_q;
  assign id_pc             = id_pc_q;
  assign id_pc4            = id_pc4_q;
  assign id_valid          = id_valid_q;
  assign target_misaligned = misalign_q;

endmodule : if_stage
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_if_stage : scoreboard bench for the fetch stage.  Rev 1.0       |
// +--------------------------------------------------------------------+
module tb_if_stage;
  import if_stage_pkg::*;

  localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] C_NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] irom_addr;
  logic [31:0] irom_inst;
  logic        stall;
  logic        ex_valid;
  logic [1:0]  ex_npc_op;
  logic        ex_br_taken;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_rs1;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic        id_valid;
  logic        redirect;
  logic        target_misaligned;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(C_RESET_PC), .NOP_INST(C_NOP)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .irom_addr         (irom_addr),
    .irom_inst         (irom_inst),
    .stall             (stall),
    .ex_valid          (ex_valid),
    .ex_npc_op         (ex_npc_op),
    .ex_br_taken       (ex_br_taken),
    .ex_pc             (ex_pc),
    .ex_imm            (ex_imm),
    .ex_rs1            (ex_rs1),
    .id_inst           (id_inst),
    .id_pc             (id_pc),
    .id_pc4            (id_pc4),
    .id_valid          (id_valid),
    .redirect          (redirect),
    .target_misaligned (target_misaligned)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'd0) return 32'h0050_0093;
    return a ^ 32'h1234_5013;
  endfunction

  always_comb irom_inst = rom(irom_addr);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] ipc;
    logic [31:0] pc4;
    logic        valid;
    logic        mis;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_pc, m_inst, m_ipc, m_pc4;
  logic        m_valid, m_mis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, predict, push, then pop and compare after the edge.
  task automatic step(input logic rn, input logic st, input logic ev, input logic [1:0] op,
                      input logic br, input logic [31:0] epc, input logic [31:0] imm,
                      input logic [31:0] rs1);
    logic        r;
    logic [31:0] tgt;
    logic        mis_n;
    exp_t        e;
    exp_t        got;
    rst_n = rn; stall = st; ex_valid = ev; ex_npc_op = op;
    ex_br_taken = br; ex_pc = epc; ex_imm = imm; ex_rs1 = rs1;
    #1;
    r = ev && (op == 2'b10 || op == 2'b11 || (op == 2'b01 && br));
    chk("redirect", {31'd0, redirect}, {31'd0, r});
    if (op == 2'b11) tgt = (rs1 + imm) & ~32'd1;
    else             tgt = epc + imm;
    mis_n = r && tgt[1];
    if (tgt[1]) tgt[1:0] = 2'b00;
    if (!rn) begin
      m_pc = C_RESET_PC; m_inst = C_NOP; m_ipc = 0; m_pc4 = 0; m_valid = 0; m_mis = 0;
    end else begin
      if (r) begin
        m_pc = tgt; m_inst = C_NOP; m_valid = 0;
      end else if (!st) begin
        m_inst = rom(m_pc); m_ipc = m_pc; m_pc4 = m_pc + 4; m_pc = m_pc + 4; m_valid = 1;
      end
      m_mis = mis_n;
    end
    e.pc = m_pc; e.inst = m_inst; e.ipc = m_ipc; e.pc4 = m_pc4; e.valid = m_valid; e.mis = m_mis;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      chk("irom_addr", irom_addr, got.pc);
      chk("id_inst", id_inst, got.inst);
      chk("id_pc", id_pc, got.ipc);
      chk("id_pc4", id_pc4, got.pc4);
      chk("id_valid", {31'd0, id_valid}, {31'd0, got.valid});
      chk("target_misaligned", {31'd0, target_misaligned}, {31'd0, got.mis});
    end
    @(negedge clk);
  endtask

  task automatic nrm();
    step(1, 0, 0, NPC_PC4, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 0; stall = 0; ex_valid = 0; ex_npc_op = 2'b00; ex_br_taken = 0;
    ex_pc = 0; ex_imm = 0; ex_rs1 = 0;
    m_pc = 32'hDEAD_BEEF; m_inst = 0; m_ipc = 0; m_pc4 = 0; m_valid = 0; m_mis = 0;
    @(negedge clk);
    step(0, 0, 0, NPC_PC4, 0, 0, 0, 0);
    step(0, 0, 0, NPC_PC4, 0, 0, 0, 0);
    chk("first_fetch_addr", irom_addr, C_RESET_PC);
    nrm();
    chk("first_inst", id_inst, 32'h0050_0093);
    nrm();
    nrm();
    // Taken branch back to 0x08, then the same branch not taken.
    step(1, 0, 1, NPC_JMP, 1, 32'h10, 32'hFFFF_FFF8, 0);
    step(1, 0, 1, NPC_JMP, 0, 32'h10, 32'hFFFF_FFF8, 0);
    // JALR, aligned and halfword-misaligned targets.
    step(1, 0, 1, NPC_JALR, 0, 0, 32'd4, 32'h101);
    nrm();
    step(1, 0, 1, NPC_JALR, 0, 0, 32'd0, 32'h102);
    nrm();
    nrm();
    // Reach pc=0x20 with a valid IF/ID, stall 3 cycles, then stall plus JAL.
    step(1, 0, 1, NPC_JAL, 0, 32'h0C, 32'h10, 0);
    nrm();
    repeat (3) step(1, 1, 0, NPC_PC4, 0, 0, 0, 0);
    step(1, 1, 1, NPC_JAL, 0, 32'h1C, 32'h40, 0);
    nrm();
    // Wrap from the top of the address space.
    step(1, 0, 1, NPC_JAL, 0, 32'h0, 32'hFFFF_FFFC, 0);
    nrm();
    step(1, 0, 0, NPC_JAL, 1, 32'h0, 32'h100, 0);
    step(1, 0, 0, NPC_JALR, 1, 32'h0, 32'h100, 32'h8);
    // Reset coincident with a misaligned JAL redirect.
    step(0, 0, 1, NPC_JAL, 0, 32'h0, 32'h102, 0);
    nrm();
    for (int i = 0; i < 60; i++) begin
      step(($urandom_range(0, 15) != 0), ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
           2'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom, $urandom, $urandom);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_if_stage
`default_nettype wire
